dm_access_unit: RTL and testbench

//   Load/store front end sitting directly upstream of the word-addressed data memory.

---
 rtl/dm_access_unit.sv | 151 +++++++++++++++
 tb/tb_dm_access_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// Load/store front end for a word-addressed synchronous data memory.
// Sub-word stores are read-modify-write; sub-word loads are sign/zero extended.
module dm_access_unit #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              dm_r,
  output logic              dm_w,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StErr} state_e;

  state_e state_q, state_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              accept;
  logic              misaligned;
  logic [DATA_W-1:0] lane_shift;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;

  always_comb begin
    misaligned = 1'b0;
    unique case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (misaligned) begin
            state_d = StErr;
          end else if (req_we && (req_size == 2'b10)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = StCap;
      StCap:   state_d = StIdle;
      StWr:    state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    lane_shift = dm_rdata >> {off_q, 3'b000};
    load_data  = dm_rdata;
    merged     = dm_rdata;
    unique case (size_q)
      2'b00: begin
        load_data = {{(DATA_W-8){signed_q & lane_shift[7]}}, lane_shift[7:0]};
        merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_data = {{(DATA_W-16){signed_q & lane_shift[15]}}, lane_shift[15:0]};
        merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        load_data = dm_rdata;
        merged    = wdata_q;
      end
    endcase
  end

  assign dm_r    = (state_q == StRd);
  assign dm_w    = (state_q == StWr) || ((state_q == StCap) && we_q);
  assign dm_addr = waddr_q;

  always_comb begin
    dm_wdata = '0;
    if (state_q == StWr) begin
      dm_wdata = wdata_q;
    end else if ((state_q == StCap) && we_q) begin
      dm_wdata = merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      waddr_q      <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= (state_q == StCap) || (state_q == StWr) || (state_q == StErr);
      resp_err_q   <= (state_q == StErr);
      resp_rdata_q <= ((state_q == StCap) && !we_q) ? load_data : '0;
      if (accept) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        off_q    <= req_addr[1:0];
        waddr_q  <= req_addr[ADDR_W+1:2];
        wdata_q  <= req_wdata;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: synchronous memory model plus a byte-array reference model.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_r, dm_w;
  logic [4:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;

  int errors = 0;
  int checks = 0;

  dm_access_unit #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_r(dm_r),
    .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Memory the DUT drives, with a preload port used during reset.
  logic [31:0] mem [32];
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  int          nr = 0, nw = 0, overlap = 0;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (dm_w) mem[dm_addr] <= dm_wdata;
    if (dm_r) dm_rdata <= mem[dm_addr];
    if (dm_r) nr <= nr + 1;
    if (dm_w) begin
      nw     <= nw + 1;
      w_addr <= dm_addr;
      w_data <= dm_wdata;
    end
    if (dm_r && dm_w) overlap <= overlap + 1;
  end

  // Reference model: 128 little-endian bytes.
  logic [7:0] ref_mem [128];

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]};
  endfunction

  task automatic ref_access(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] ad, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat,
                            output int enr, output int enw, output logic [31:0] ww);
    int a, nb;
    logic [31:0] v;
    a   = int'(ad % 128);
    nb  = 1 << sz;
    rd  = 0; er = 0; lat = 2; enr = 1; enw = 0; ww = 0;
    if (sz == 3 || (a % nb) != 0) begin
      er = 1; lat = 1; enr = 0;
    end else if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[a+i] = wd[8*i +: 8];
      enw = 1;
      if (sz == 2) begin lat = 1; enr = 0; end
      ww = ref_word(a / 4);
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[a+i]) << (8*i));
      if (sg && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8*nb));
      rd = v;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int dr, output int dw);
    int r0, w0, n;
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    r0 = nr; w0 = nw;
    @(posedge clk); #1;
    // Scramble the request fields: the DUT must use its latched copy.
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = -1; rd = 'x; er = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = i; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    dr = nr - r0; dw = nw - w0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 5'(i);
      ld_data = (i == 1) ? 32'h0000_9876 : $urandom;
      for (int b = 0; b < 4; b++) ref_mem[i*4+b] = ld_data[8*b +: 8];
    end
    @(negedge clk);
    ld_en = 1'b0;
    checks++;
    if ({resp_valid, resp_err, dm_r, dm_w} !== 4'b0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b e=%b r=%b w=%b d=%h exp all zero",
               resp_valid, resp_err, dm_r, dm_w, resp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got ready=%b valid=%b exp ready=1 valid=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_directed();
    logic        t_we [10] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    logic [1:0]  t_sz [10] = '{2, 0, 0, 1, 1, 2, 2, 2, 2, 3};
    logic        t_sg [10] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    logic [31:0] t_ad [10] = '{32'h4, 32'h5, 32'h5, 32'h4, 32'h6, 32'h4, 32'h84, 32'h4,
                               32'h2, 32'h8};
    logic [31:0] t_wd [10] = '{0, 0, 0, 0, 32'hABCD, 0, 32'h1234_5678, 0, 0, 0};
    int lat, dr, dw, elat, enr, enw;
    logic [31:0] rd, erd, ww;
    logic er, eer;
    for (int k = 0; k < 10; k++) begin
      do_req(t_we[k], t_sz[k], t_sg[k], t_ad[k], t_wd[k], lat, rd, er, dr, dw);
      ref_access(t_we[k], t_sz[k], t_sg[k], t_ad[k], t_wd[k], erd, eer, elat, enr, enw, ww);
      checks += 4;
      if (lat !== elat) begin errors++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", k, lat, elat); end
      if (rd !== erd) begin errors++; $display("FAIL dir_rdata[%0d] got=%h exp=%h", k, rd, erd); end
      if (er !== eer) begin errors++; $display("FAIL dir_err[%0d] got=%b exp=%b", k, er, eer); end
      if (dr !== enr || dw !== enw) begin
        errors++;
        $display("FAIL dir_strobes[%0d] got r=%0d w=%0d exp r=%0d w=%0d", k, dr, dw, enr, enw);
      end
      if (enw == 1) begin
        checks++;
        if (w_addr !== t_ad[k][6:2] || w_data !== ww) begin
          errors++;
          $display("FAIL dir_write[%0d] got a=%0d d=%h exp a=%0d d=%h", k, w_addr, w_data,
                   t_ad[k][6:2], ww);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL dir_pulse[%0d] got=1 exp=0", k); end
    end
  endtask

  task automatic test_random();
    logic we, sg, er, eer;
    logic [1:0] sz;
    logic [31:0] ad, wd, rd, erd, ww;
    int lat, dr, dw, elat, enr, enw;
    for (int k = 0; k < 80; k++) begin
      we = 1'($urandom); sg = 1'($urandom); wd = $urandom;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0 && sz != 3) ad = ad & ~((32'd1 << sz) - 1);
      do_req(we, sz, sg, ad, wd, lat, rd, er, dr, dw);
      ref_access(we, sz, sg, ad, wd, erd, eer, elat, enr, enw, ww);
      checks += 3;
      if (lat !== elat) begin errors++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", k, lat, elat); end
      if (rd !== erd || er !== eer) begin
        errors++;
        $display("FAIL rnd_resp[%0d] got d=%h e=%b exp d=%h e=%b", k, rd, er, erd, eer);
      end
      if (dr !== enr || dw !== enw) begin
        errors++;
        $display("FAIL rnd_strobes[%0d] got r=%0d w=%0d exp r=%0d w=%0d", k, dr, dw, enr, enw);
      end
      if (enw == 1) begin
        checks++;
        if (w_addr !== ad[6:2] || w_data !== ww) begin
          errors++;
          $display("FAIL rnd_write[%0d] got a=%0d d=%h exp a=%0d d=%h", k, w_addr, w_data,
                   ad[6:2], ww);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    bit seen;
    w0 = nw;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h9; req_wdata = 32'hA5;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dm_w !== 1'b0) begin errors++; $display("FAIL mid_dm_w got=%b exp=0", dm_w); end
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (resp_valid) seen = 1; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (resp_valid) seen = 1; end
    checks += 3;
    if (seen) begin errors++; $display("FAIL mid_resp got=1 exp=0"); end
    if (nw - w0 !== 0) begin errors++; $display("FAIL mid_writes got=%0d exp=0", nw - w0); end
    if (mem[2] !== ref_word(2)) begin
      errors++; $display("FAIL mid_mem got=%h exp=%h", mem[2], ref_word(2));
    end
  endtask

  task automatic test_back_to_back();
    logic        b_we [6] = '{1, 0, 1, 0, 0, 1};
    logic [1:0]  b_sz [6] = '{2, 2, 0, 0, 3, 1};
    logic [31:0] b_ad [6] = '{32'h10, 32'h10, 32'h13, 32'h10, 32'h10, 32'h1A};
    logic [31:0] b_wd [6] = '{32'hDEAD_BEEF, 0, 32'h77, 0, 0, 32'h55AA};
    logic [31:0] erd, ww;
    logic eer;
    int elat, enr, enw, lat, waits;
    @(negedge clk);
    req_we = b_we[0]; req_size = b_sz[0]; req_signed = 1'b1; req_addr = b_ad[0];
    req_wdata = b_wd[0]; req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      waits = 0;
      while (!req_ready && waits < 20) begin @(negedge clk); waits++; end
      @(posedge clk); #1;
      if (k < 5) begin
        req_we = b_we[k+1]; req_size = b_sz[k+1]; req_addr = b_ad[k+1]; req_wdata = b_wd[k+1];
      end else begin
        req_valid = 1'b0;
      end
      ref_access(b_we[k], b_sz[k], 1'b1, b_ad[k], b_wd[k], erd, eer, elat, enr, enw, ww);
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
        @(posedge clk); #1;
        if (resp_valid) begin lat = i; break; end
      end
      checks += 3;
      if (lat !== elat) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", k, lat, elat); end
      if (resp_rdata !== erd || resp_err !== eer) begin
        errors++;
        $display("FAIL b2b_resp[%0d] got d=%h e=%b exp d=%h e=%b", k, resp_rdata, resp_err, erd, eer);
      end
      if (req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, req_ready);
      end
    end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap got=%0d exp=0", overlap); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
